// File: rtl/rv32i_types.sv
// rv32i_types: shared widths and the common data bus packet carried from functional units to the CDB
package rv32i_types;
  localparam int NUM_CDB_REQ = 5;
  localparam int ROB_IDX_W = 5;
  localparam int PREG_W = 6;
  localparam int ARCH_REG_W = 5;
  localparam int XLEN = 32;
  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PREG_W-1:0] pd;
    logic [ARCH_REG_W-1:0] rd;
    logic [XLEN-1:0] data;
  } cdb_pkt_t;
endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; req/ptr in, one-hot gnt, encoded idx and any out
module rr_arbiter #(
  parameter int N = 5,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  int j;
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        idx = IW'(j);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-unit result buffers round-robin arbitrated onto one registered CDB; clk/rst, req_valid/req_ready/req_pkt in, flush, cdb_valid/cdb_pkt/cdb_src out
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_REQ = NUM_CDB_REQ,
  parameter int ROB_IDX_W = rv32i_types::ROB_IDX_W,
  parameter int PREG_W = rv32i_types::PREG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  cdb_pkt_t           req_pkt [NUM_REQ],
  input  logic               flush,
  output logic               cdb_valid,
  output cdb_pkt_t           cdb_pkt,
  output logic [NUM_REQ-1:0] cdb_src
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  if (ROB_IDX_W + PREG_W + ARCH_REG_W + XLEN != $bits(cdb_pkt_t)) begin : g_bad_width
    $error("cdb_arbiter widths disagree with cdb_pkt_t");
  end
  logic [NUM_REQ-1:0] buf_valid, gnt_raw, grant, load;
  cdb_pkt_t buf_pkt [NUM_REQ];
  logic [IW-1:0] rr_ptr, gnt_idx;
  logic gnt_any, win;
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req(buf_valid),
    .ptr(rr_ptr),
    .gnt(gnt_raw),
    .idx(gnt_idx),
    .any(gnt_any)
  );
  always_comb begin
    win = gnt_any & ~flush;
    grant = win ? gnt_raw : '0;
    req_ready = ~buf_valid | grant;
    load = req_valid & req_ready & {NUM_REQ{~flush}};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= '0;
      rr_ptr <= '0;
      cdb_valid <= 1'b0;
      cdb_pkt <= '0;
      cdb_src <= '0;
      for (int i = 0; i < NUM_REQ; i++) buf_pkt[i] <= '0;
    end else begin
      buf_valid <= flush ? '0 : (buf_valid & ~grant) | load;
      for (int i = 0; i < NUM_REQ; i++) if (load[i]) buf_pkt[i] <= req_pkt[i];
      cdb_valid <= win;
      cdb_src <= grant;
      if (win) begin
        cdb_pkt <= buf_pkt[gnt_idx];
        rr_ptr <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 5, number of functional-unit requesters (0=alu, 1=mul, 2=div, 3=mem, 4=bru).
REQ-002 SHALL have parameter ROB_IDX_W, default 5, ROB index width.
REQ-003 SHALL have parameter PREG_W, default 6, physical register index width.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester result valid.
REQ-007 SHALL have port req_ready  output  NUM_REQ  per-requester result accepted this cycle when valid.
REQ-008 SHALL have port req_pkt  input  NUM_REQ x cdb_pkt_t  per-requester payload: rob_idx, pd, rd[4:0], data[31:0].
REQ-009 SHALL have port flush  input  1  mispredict squash; discards all pending results.
REQ-010 SHALL have port cdb_valid  output  1  broadcast valid.
REQ-011 SHALL have port cdb_pkt  output  cdb_pkt_t  broadcast payload.
REQ-012 SHALL have port cdb_src  output  NUM_REQ  one-hot source of current broadcast; all zero when cdb_valid=0.

Function
REQ-013 SHALL hold one single-entry buffer (buf_valid[i], buf_pkt[i]) per requester.
REQ-014 SHALL drive req_ready[i] = ~buf_valid[i] | grant[i], and SHALL NOT depend on req_valid.
REQ-015 SHALL load buf[i] at the edge where req_valid[i] & req_ready[i] & ~flush.
REQ-016 SHALL clear buf_valid[i] on the edge where grant[i]=1 and buf[i] is not reloaded.
REQ-017 SHALL assert at most one grant per cycle, and only to a requester with buf_valid=1.
REQ-018 SHALL select the grant round-robin: the first i with buf_valid[i]=1, scanning from rr_ptr upward modulo NUM_REQ.
REQ-019 SHALL update rr_ptr to (granted index + 1) mod NUM_REQ after each grant, and SHALL leave it unchanged when no grant occurs.
REQ-020 SHALL register the granted buffer into cdb_pkt/cdb_src with cdb_valid=1, giving a handshake-to-broadcast latency of exactly 2 cycles (accept at t, grant at t+1, visible at t+2).
REQ-021 SHALL deassert cdb_valid in any cycle following a cycle with no grant; cdb_pkt then holds its last value.
REQ-022 SHALL broadcast packets with rd=0 or pd=0 unchanged; ROB completion needs them.
REQ-023 SHALL allow same-cycle grant and reload of one buffer, sustaining 1 result/cycle per requester when uncontended.
REQ-024 SHALL guarantee any buffered result broadcasts within NUM_REQ cycles of buffering, absent flush.
REQ-025 SHALL on flush clear all buf_valid, suppress grant, drop concurrent handshakes, and force cdb_valid=0 next cycle; rr_ptr is kept.
REQ-026 SHALL produce cdb_valid=1 in the cycle after flush only from a handshake accepted after the flush cycle.

Reset
REQ-027 SHALL on rst clear buf_valid, rr_ptr=0, cdb_valid=0, cdb_pkt=0, cdb_src=0, asynchronously.
REQ-028 SHALL drive req_ready all-ones while no buffer is full, including immediately after reset.
REQ-029 SHALL on reset mid-operation discard all buffered and in-flight results.

Structure
REQ-030 SHALL take cdb_pkt_t, NUM_CDB_REQ and the index widths from rv32i_types.
REQ-031 SHALL instantiate one sub-module, rr_arbiter: request vector plus pointer in, one-hot grant and encoded index out; combinational only.

Verification
REQ-032 Reset then idle -> req_ready=5'b11111, cdb_valid=0 for 10 cycles.
REQ-033 alu only, valid at t with rob_idx=3, data=0xDEADBEEF -> cdb_valid=1 at t+2, cdb_src=5'b00001, identical payload.
REQ-034 All 5 valid at t with rr_ptr=0, held every cycle -> broadcasts at t+2..t+6 in order alu, mul, div, mem, bru, then alu again; no gaps.
REQ-035 mul holds valid for 4 consecutive packets, others idle -> 4 back-to-back broadcasts; req_ready[1]=1 throughout.
REQ-036 Buffers for div and mem full, flush at t with alu valid -> cdb_valid=0 at t+1 and t+2, alu packet never broadcast, buf_valid all 0.
REQ-037 rst asserted mid-cycle while 3 buffers full -> outputs 0 without a clock edge; no stale broadcast after rst deasserts.
